svc_axi_stripe_rd_seg: RTL and testbench
========================================

Name: svc_axi_stripe_rd_seg

Overview:
AXI4 read-only striping splitter for framebuffer readout across NUM_S memory subordinates, such as the iCE40 SRAM controllers. It generalises fixed one-beat striping to a parametrised stripe granularity of STRIPE_BEATS beats per subordinate. An upstream INCR burst may cross any number of stripe boundaries; the block splits it into per-subordinate segment bursts and reassembles the R data in order. It sits between a display or readback manager and the subordinate AR/R channels. Write channels are handled elsewhere.

Parameters:
NUM_S, 2, number of subordinates; power of 2, at least 2.
AXI_ADDR_WIDTH, 21, upstream byte address width; subordinate width is AXI_ADDR_WIDTH-$clog2(NUM_S).
AXI_DATA_WIDTH, 16, data width; O = $clog2(AXI_DATA_WIDTH/8) byte-offset bits.
AXI_ID_WIDTH, 6, ID width, passed through unchanged.
STRIPE_BEATS, 4, consecutive beats mapped to one subordinate; power of 2, at least 1.
SEG_FIFO_DEPTH, 4, depth of the segment-order FIFO; power of 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axi_arvalid/arready  in/out  1  upstream AR handshake
s_axi_arid  in  AXI_ID_WIDTH  upstream ID
s_axi_araddr  in  AXI_ADDR_WIDTH  byte address
s_axi_arlen/arsize/arburst  in  8/3/2  burst attributes
s_axi_rvalid/rready  out/in  1  upstream R handshake
s_axi_rid/rdata/rresp/rlast  out  AXI_ID_WIDTH/AXI_DATA_WIDTH/2/1  upstream R payload
m_axi_arvalid/arready  out/in  NUM_S  per-subordinate AR handshake
m_axi_arid  out  NUM_S x AXI_ID_WIDTH  segment ID, equal to the latched arid
m_axi_araddr  out  NUM_S x (AXI_ADDR_WIDTH-$clog2(NUM_S))  subordinate byte address
m_axi_arlen/arsize/arburst  out  NUM_S x 8/3/2  segment length; arsize=O; arburst=INCR
m_axi_rvalid/rready  in/out  NUM_S  per-subordinate R handshake
m_axi_rid/rdata/rresp/rlast  in  NUM_S x ...  subordinate R payload

Behaviour:
- One clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: s_axi_arready=0, s_axi_rvalid=0, m_axi_arvalid=0, m_axi_rready=0. The FSM goes to IDLE and the FIFO is emptied.
  - s_axi_arready rises the first cycle after rst deasserts.
  - Asserting rst mid-burst abandons all state with no completion.
- States:
  - IDLE: arready=1. On the AR handshake, latch id, addr, len and attributes. Go to ISSUE, or to ERR if arburst!=INCR or arsize!=O.
  - ISSUE: issue segments one at a time; R forwarding runs concurrently. After the final segment's AR handshake, go to DRAIN.
  - DRAIN: forward the remaining R beats. After the upstream R handshake with rlast, return to IDLE; arready=1 next cycle.
  - ERR: send arlen+1 beats with rresp=SLVERR (2'b10), rdata=0 and rlast on the final beat. No subordinate is touched. Then return to IDLE.
- Segment math (B = current beat index = addr>>O, SB = STRIPE_BEATS):
  - stripe = B/SB; sub = stripe mod NUM_S; row = stripe/NUM_S.
  - sub_addr = (row*SB + B mod SB)<<O.
  - seg_len_beats = min(remaining, SB - B mod SB); m_axi_arlen = seg_len_beats-1.
  - After each AR handshake: B += seg_len_beats; remaining -= seg_len_beats.
  - Wrap from sub NUM_S-1 to sub 0 increments row.
- m_axi_arvalid[sub] is registered and held stable until arready. Only one m_axi_arvalid bit is high at any time.
- On each segment AR handshake, push the sub index into the segment FIFO. Issue stalls while the FIFO is full.
- R path:
  - The FIFO head selects the subordinate. m_axi_rready[head] = s_axi_rready && FIFO non-empty; all other rready bits are 0.
  - s_axi_rvalid = m_axi_rvalid[head]. rdata and rresp are forwarded per beat; rid = latched id.
  - m_axi_rlast on a beat pops the FIFO.
  - s_axi_rlast = sub rlast && this is the final segment (tracked by an upstream beat counter reaching len).
  - Combinational pass-through, zero added latency; the same-cycle pop and push are legal.
- The FIFO empty condition gates s_axi_rvalid low.
- Subordinate rid is ignored.

Decomposition:
- Package svc_axi_stripe_pkg holds the state enum (IDLE, ISSUE, DRAIN, ERR) and the constants AXI_BURST_INCR=2'b01 and AXI_RESP_SLVERR=2'b10.
- One sub-module, svc_sync_fifo_seg: a synchronous FIFO of $clog2(NUM_S)-bit entries with full and empty flags.

Test Plan:
All scenarios use NUM_S=2, DATA=16 (O=1) and STRIPE_BEATS=4.
1. araddr=0x0, arlen=7: two segments, sub0 addr 0x0 len 3, then sub1 addr 0x0 len 3. Upstream receives 8 beats in order with rlast on beat 8.
2. araddr=0x6, arlen=2: sub0 addr 0x6 len 0, then sub1 addr 0x0 len 1. Upstream receives 3 beats.
3. Wrap case, araddr=0x18, arlen=5: sub1 addr 0x8 len 3, then sub0 addr 0x10 len 1. rlast only on beat 6.
4. arburst=FIXED, arlen=3: 4 SLVERR beats with rlast on the 4th. m_axi_arvalid stays 0 throughout.
5. Randomised s_axi_rready and m_axi_arready stalls with arlen=31: 8 segments, FIFO full stalls issue, data order matches a memory model, no beat is lost or duplicated.
6. rst=1 pulsed mid-burst during case 1: all valids are 0 the next cycle, arready=1 the cycle after release, and a new burst completes correctly.

Source files
------------

// File: rtl/svc_axi_stripe_pkg.sv
// Shared types and AXI encodings for the striped AXI4 read splitter.
package svc_axi_stripe_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERR} state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
endpackage

// File: rtl/svc_axi_stripe_rd_seg_fifo.sv
// Segment-order FIFO: remembers which subordinate owns each issued segment.
module svc_sync_fifo_seg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/svc_axi_stripe_rd_seg.sv
// AXI4 read splitter: cuts INCR bursts at stripe boundaries across NUM_S
// subordinates and returns the R beats upstream in original order.
module svc_axi_stripe_rd_seg
  import svc_axi_stripe_pkg::*;
#(
  parameter int NUM_S          = 2,
  parameter int AXI_ADDR_WIDTH = 21,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int STRIPE_BEATS   = 4,
  parameter int SEG_FIFO_DEPTH = 4,
  localparam int SAW           = AXI_ADDR_WIDTH - $clog2(NUM_S)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       s_axi_arvalid,
  output logic                                       s_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]                    s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]                  s_axi_araddr,
  input  logic [7:0]                                 s_axi_arlen,
  input  logic [2:0]                                 s_axi_arsize,
  input  logic [1:0]                                 s_axi_arburst,
  output logic                                       s_axi_rvalid,
  input  logic                                       s_axi_rready,
  output logic [AXI_ID_WIDTH-1:0]                    s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]                  s_axi_rdata,
  output logic [1:0]                                 s_axi_rresp,
  output logic                                       s_axi_rlast,
  output logic [NUM_S-1:0]                           m_axi_arvalid,
  input  logic [NUM_S-1:0]                           m_axi_arready,
  output logic [NUM_S-1:0][AXI_ID_WIDTH-1:0]         m_axi_arid,
  output logic [NUM_S-1:0][SAW-1:0]                  m_axi_araddr,
  output logic [NUM_S-1:0][7:0]                      m_axi_arlen,
  output logic [NUM_S-1:0][2:0]                      m_axi_arsize,
  output logic [NUM_S-1:0][1:0]                      m_axi_arburst,
  input  logic [NUM_S-1:0]                           m_axi_rvalid,
  output logic [NUM_S-1:0]                           m_axi_rready,
  input  logic [NUM_S-1:0][AXI_ID_WIDTH-1:0]         m_axi_rid,
  input  logic [NUM_S-1:0][AXI_DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [NUM_S-1:0][1:0]                      m_axi_rresp,
  input  logic [NUM_S-1:0]                           m_axi_rlast
);
  localparam int O    = $clog2(AXI_DATA_WIDTH / 8);
  localparam int NS_W = $clog2(NUM_S);
  localparam int SB_W = $clog2(STRIPE_BEATS);
  localparam int BW   = AXI_ADDR_WIDTH - O;

  state_e                  r_state;
  logic                    r_arready;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [BW-1:0]           r_beat;
  logic [8:0]              r_remaining;
  logic [7:0]              r_len;
  logic [7:0]              r_rcnt;
  logic [NUM_S-1:0]        r_arvalid;
  logic [NS_W-1:0]         r_ar_sub;
  logic [SAW-1:0]          r_araddr;
  logic [7:0]              r_arlen;
  logic [8:0]              r_seg_beats;

  logic [BW-1:0]   w_stripe, w_row, w_off, w_sub_beat;
  logic [NS_W-1:0] w_sub, w_head;
  logic [SAW-1:0]  w_sub_addr;
  logic [8:0]      w_room, w_seg;
  logic            w_ar_hs, w_up_hs, w_pop, w_full, w_empty, w_final_beat;
  logic            w_unused;

  // Stripe geometry of the next beat to issue.
  assign w_stripe   = r_beat >> SB_W;
  assign w_sub      = w_stripe[NS_W-1:0];
  assign w_row      = w_stripe >> NS_W;
  assign w_off      = r_beat & BW'(STRIPE_BEATS - 1);
  assign w_sub_beat = (w_row << SB_W) | w_off;
  assign w_sub_addr = SAW'(w_sub_beat << O);
  assign w_room     = 9'(STRIPE_BEATS) - 9'(w_off);
  assign w_seg      = (r_remaining < w_room) ? r_remaining : w_room;

  assign w_ar_hs      = |(r_arvalid & m_axi_arready);
  assign w_up_hs      = s_axi_rvalid && s_axi_rready;
  assign w_final_beat = (r_rcnt == r_len);
  assign w_pop        = w_up_hs && !w_empty && m_axi_rlast[w_head];

  svc_sync_fifo_seg #(.WIDTH(NS_W), .DEPTH(SEG_FIFO_DEPTH)) u_seg_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ar_hs),
    .i_data  (r_ar_sub),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    m_axi_rready = '0;
    s_axi_rvalid = 1'b0;
    s_axi_rdata  = '0;
    s_axi_rresp  = AXI_RESP_OKAY;
    s_axi_rlast  = 1'b0;
    if (r_state == ERR) begin
      s_axi_rvalid = 1'b1;
      s_axi_rresp  = AXI_RESP_SLVERR;
      s_axi_rlast  = w_final_beat;
    end else if (!w_empty) begin
      s_axi_rvalid         = m_axi_rvalid[w_head];
      s_axi_rdata          = m_axi_rdata[w_head];
      s_axi_rresp          = m_axi_rresp[w_head];
      s_axi_rlast          = m_axi_rlast[w_head] && w_final_beat;
      m_axi_rready[w_head] = s_axi_rready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_arready   <= 1'b0;
      r_arvalid   <= '0;
      r_id        <= '0;
      r_beat      <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_rcnt      <= '0;
      r_ar_sub    <= '0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_seg_beats <= '0;
    end else begin
      if (w_up_hs) r_rcnt <= r_rcnt + 8'd1;
      case (r_state)
        IDLE: begin
          if (r_arready && s_axi_arvalid) begin
            r_arready   <= 1'b0;
            r_id        <= s_axi_arid;
            r_beat      <= s_axi_araddr[AXI_ADDR_WIDTH-1:O];
            r_len       <= s_axi_arlen;
            r_remaining <= {1'b0, s_axi_arlen} + 9'd1;
            r_rcnt      <= '0;
            r_state     <= (s_axi_arburst != AXI_BURST_INCR || s_axi_arsize != 3'(O)) ? ERR : ISSUE;
          end else begin
            r_arready <= 1'b1;
          end
        end
        ISSUE: begin
          if (w_ar_hs) begin
            r_arvalid   <= '0;
            r_beat      <= r_beat + BW'(r_seg_beats);
            r_remaining <= r_remaining - r_seg_beats;
            if (r_remaining == r_seg_beats) r_state <= DRAIN;
          end else if (r_arvalid == '0 && !w_full) begin
            // A raised request always has FIFO room: only our own handshakes push.
            r_arvalid   <= NUM_S'(1) << w_sub;
            r_ar_sub    <= w_sub;
            r_araddr    <= w_sub_addr;
            r_arlen     <= 8'(w_seg - 9'd1);
            r_seg_beats <= w_seg;
          end
        end
        DRAIN, ERR: begin
          if (w_up_hs && s_axi_rlast) begin
            r_state   <= IDLE;
            r_arready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rid     = r_id;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_arid    = {NUM_S{r_id}};
  assign m_axi_araddr  = {NUM_S{r_araddr}};
  assign m_axi_arlen   = {NUM_S{r_arlen}};
  assign m_axi_arsize  = {NUM_S{3'(O)}};
  assign m_axi_arburst = {NUM_S{AXI_BURST_INCR}};

  // Subordinate rid and sub-beat address bits carry no information here.
  assign w_unused = ^{m_axi_rid, s_axi_araddr};
endmodule

// File: tb/tb_svc_axi_stripe_rd_seg.sv
// Self-checking bench: table vectors, randomised stalled bursts and reset
// abort, with subordinate memories modelled from the stripe mapping.
module tb_svc_axi_stripe_rd_seg;
  localparam int NS = 2, AW = 21, DW = 16, IW = 6, SB = 4, DEPTH = 4;
  localparam int SAW = AW - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                        s_axi_arvalid, s_axi_arready;
  logic [IW-1:0]               s_axi_arid;
  logic [AW-1:0]               s_axi_araddr;
  logic [7:0]                  s_axi_arlen;
  logic [2:0]                  s_axi_arsize;
  logic [1:0]                  s_axi_arburst;
  logic                        s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [IW-1:0]               s_axi_rid;
  logic [DW-1:0]               s_axi_rdata;
  logic [1:0]                  s_axi_rresp;
  logic [NS-1:0]               m_axi_arvalid, m_axi_arready;
  logic [NS-1:0][IW-1:0]       m_axi_arid;
  logic [NS-1:0][SAW-1:0]      m_axi_araddr;
  logic [NS-1:0][7:0]          m_axi_arlen;
  logic [NS-1:0][2:0]          m_axi_arsize;
  logic [NS-1:0][1:0]          m_axi_arburst;
  logic [NS-1:0]               m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [NS-1:0][IW-1:0]       m_axi_rid;
  logic [NS-1:0][DW-1:0]       m_axi_rdata;
  logic [NS-1:0][1:0]          m_axi_rresp;

  svc_axi_stripe_rd_seg #(
    .NUM_S(NS), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .STRIPE_BEATS(SB), .SEG_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Global framebuffer contents, indexed by upstream beat number.
  function automatic logic [15:0] mem_word(input int gb);
    return 16'(gb * 40503 + 4660);
  endfunction
  function automatic logic [1:0] mem_resp(input int gb);
    return (gb % 7 == 3) ? 2'b01 : 2'b00;
  endfunction
  // Which global beat lives at a given beat of a subordinate's local space.
  function automatic int sub_to_global(input int s, input int sub_beat);
    return ((sub_beat / SB) * NS + s) * SB + (sub_beat % SB);
  endfunction

  // Expectations owned by the main sequence.
  int            exp_b0, exp_len, start_tok = 0;
  bit            exp_err, stall;
  logic [IW-1:0] exp_id;

  // State owned by the subordinate/upstream responder.
  int   q_beat[NS][16], q_len[NS][16], q_wp[NS], q_rp[NS], q_idx[NS];
  int   up_cnt, log_n, seen_tok = 0, tot_ar, tot_rl;
  int   log_sub[64], log_addr[64], log_len[64];
  bit   done, any_arvalid, sm_rst, hs_up, sm_rlast;
  logic [NS-1:0] hs_ar, hs_r;
  logic [SAW-1:0] sm_addr[NS];
  logic [7:0]     sm_len[NS];
  logic [IW-1:0]  sm_id[NS];
  logic [2:0]     sm_size[NS];
  logic [1:0]     sm_burst[NS];
  logic [DW-1:0]  sm_rdata;
  logic [1:0]     sm_rresp;
  logic [IW-1:0]  sm_rid;

  initial begin : responder
    int gb, h;
    m_axi_arready = '0; m_axi_rvalid = '0; m_axi_rid = '0;
    m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = '0; s_axi_rready = 1'b0;
    up_cnt = 0; done = 0; log_n = 0; tot_ar = 0; tot_rl = 0; any_arvalid = 0;
    for (int s = 0; s < NS; s++) begin q_wp[s] = 0; q_rp[s] = 0; q_idx[s] = 0; end
    forever begin
      @(negedge clk);
      sm_rst = rst;
      hs_ar = m_axi_arvalid & m_axi_arready;
      hs_r  = m_axi_rvalid & m_axi_rready;
      for (int s = 0; s < NS; s++) begin
        sm_addr[s] = m_axi_araddr[s]; sm_len[s] = m_axi_arlen[s]; sm_id[s] = m_axi_arid[s];
        sm_size[s] = m_axi_arsize[s]; sm_burst[s] = m_axi_arburst[s];
      end
      hs_up = s_axi_rvalid && s_axi_rready;
      sm_rdata = s_axi_rdata; sm_rresp = s_axi_rresp; sm_rlast = s_axi_rlast; sm_rid = s_axi_rid;
      if (!rst) begin
        check("arvalid_onehot", 64'($countones(m_axi_arvalid) <= 1), 64'd1);
        if (|m_axi_arvalid) any_arvalid = 1;
      end
      @(posedge clk); #1;
      if (start_tok != seen_tok) begin
        seen_tok = start_tok; up_cnt = 0; done = 0; log_n = 0; any_arvalid = 0;
      end
      if (sm_rst) begin
        for (int s = 0; s < NS; s++) begin q_wp[s] = 0; q_rp[s] = 0; q_idx[s] = 0; end
        tot_ar = 0; tot_rl = 0;
      end else begin
        for (int s = 0; s < NS; s++) begin
          if (hs_ar[s]) begin
            check("seg_fifo_bound", 64'((tot_ar - tot_rl) < DEPTH), 64'd1);
            check("seg_arid", sm_id[s], exp_id);
            check("seg_arsize", sm_size[s], 3'd1);
            check("seg_arburst", sm_burst[s], 2'b01);
            if (log_n < 64) begin
              log_sub[log_n] = s; log_addr[log_n] = int'(sm_addr[s]); log_len[log_n] = int'(sm_len[s]);
            end
            log_n++;
            tot_ar++;
            q_beat[s][q_wp[s] % 16] = int'(sm_addr[s]) / 2;
            q_len[s][q_wp[s] % 16]  = int'(sm_len[s]);
            q_wp[s]++;
          end
        end
        for (int s = 0; s < NS; s++) begin
          if (hs_r[s]) begin
            if (q_idx[s] == q_len[s][q_rp[s] % 16]) begin
              q_rp[s]++; q_idx[s] = 0; tot_rl++;
            end else q_idx[s]++;
          end
        end
        if (hs_up) begin
          if (done || up_cnt > exp_len) check("extra_beat", 64'd1, 64'd0);
          else begin
            gb = exp_b0 + up_cnt;
            check("rdata", sm_rdata, exp_err ? 16'h0 : mem_word(gb));
            check("rresp", sm_rresp, exp_err ? 2'b10 : mem_resp(gb));
            check("rlast", sm_rlast, up_cnt == exp_len);
            check("rid", sm_rid, exp_id);
            up_cnt++;
            if (up_cnt == exp_len + 1) done = 1;
          end
        end
      end
      for (int s = 0; s < NS; s++) begin
        m_axi_arready[s] = !stall || ($urandom_range(0, 1) == 1);
        if (sm_rst) begin
          m_axi_rvalid[s] = 1'b0; m_axi_rlast[s] = 1'b0;
        end else if (!(m_axi_rvalid[s] && !hs_r[s])) begin
          if (q_rp[s] != q_wp[s] && (!stall || $urandom_range(0, 2) != 0)) begin
            h  = q_rp[s] % 16;
            gb = sub_to_global(s, q_beat[s][h] + q_idx[s]);
            m_axi_rvalid[s] = 1'b1;
            m_axi_rdata[s]  = mem_word(gb);
            m_axi_rresp[s]  = mem_resp(gb);
            m_axi_rlast[s]  = (q_idx[s] == q_len[s][h]);
            m_axi_rid[s]    = IW'($urandom);
          end else begin
            m_axi_rvalid[s] = 1'b0; m_axi_rlast[s] = 1'b0;
          end
        end
      end
      s_axi_rready = !stall || ($urandom_range(0, 1) == 1);
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    logic [1:0]    burst;
    logic [2:0]    size;
    int            nseg;
    int            sub[2];
    int            saddr[2];
    int            slen[2];
  } vec_t;
  vec_t vecs[5];

  task automatic set_vec(input int i, input int addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int nseg, input int s0, input int a0,
                         input int l0, input int s1, input int a1, input int l1);
    vecs[i].addr = AW'(addr); vecs[i].len = len; vecs[i].burst = burst; vecs[i].size = size;
    vecs[i].nseg = nseg;
    vecs[i].sub[0] = s0; vecs[i].saddr[0] = a0; vecs[i].slen[0] = l0;
    vecs[i].sub[1] = s1; vecs[i].saddr[1] = a1; vecs[i].slen[1] = l1;
  endtask

  task automatic start_ar(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size);
    bit ok;
    @(posedge clk); #1;
    exp_b0 = int'(addr) / 2; exp_len = len; exp_id = IW'($urandom);
    exp_err = (burst != 2'b01) || (size != 3'd1);
    start_tok++;
    s_axi_arvalid = 1'b1; s_axi_arid = exp_id; s_axi_araddr = addr;
    s_axi_arlen = 8'(len); s_axi_arsize = size; s_axi_arburst = burst;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (s_axi_arready) begin ok = 1; break; end
    end
    if (!ok) check("ar_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic run_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size);
    start_ar(addr, len, burst, size);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) break;
    end
    check("burst_done", done, 1'b1);
    check("arready_after_burst", s_axi_arready, 1'b1);
  endtask

  // Expected segments from the striping rule, using plain integer arithmetic.
  task automatic check_model_segs(input logic [AW-1:0] addr, input int len);
    int b, rem, take, stripe, i;
    b = int'(addr) / 2; rem = len + 1; i = 0;
    while (rem > 0) begin
      take   = (rem < SB - b % SB) ? rem : SB - b % SB;
      stripe = b / SB;
      if (i < log_n && i < 64) begin
        check("model_seg_sub", log_sub[i], stripe % NS);
        check("model_seg_addr", log_addr[i], ((stripe / NS) * SB + b % SB) * 2);
        check("model_seg_len", log_len[i], take - 1);
      end
      i++; b += take; rem -= take;
    end
    check("model_seg_count", log_n, i);
  endtask

  initial begin : main
    rst = 1'b1; stall = 0;
    s_axi_arvalid = 1'b0; s_axi_arid = '0; s_axi_araddr = '0;
    s_axi_arlen = '0; s_axi_arsize = 3'd1; s_axi_arburst = 2'b01;

    set_vec(0, 'h00, 7, 2'b01, 3'd1, 2, 0, 'h0, 3, 1, 'h0, 3);
    set_vec(1, 'h06, 2, 2'b01, 3'd1, 2, 0, 'h6, 0, 1, 'h0, 1);
    set_vec(2, 'h18, 5, 2'b01, 3'd1, 2, 1, 'h8, 3, 0, 'h10, 1);
    set_vec(3, 'h00, 3, 2'b00, 3'd1, 0, 0, 0, 0, 0, 0, 0);
    set_vec(4, 'h04, 1, 2'b01, 3'd0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_m_arvalid", m_axi_arvalid, 2'b00);
    check("rst_m_rready", m_axi_rready, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("arready_release_cycle", s_axi_arready, 1'b0);
    @(negedge clk);
    check("arready_after_release", s_axi_arready, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].size);
      check("vec_seg_count", log_n, vecs[i].nseg);
      if (vecs[i].nseg == 0) check("err_no_arvalid", any_arvalid, 1'b0);
      for (int j = 0; j < vecs[i].nseg; j++) begin
        if (j < log_n) begin
          check("vec_seg_sub", log_sub[j], vecs[i].sub[j]);
          check("vec_seg_addr", log_addr[j], vecs[i].saddr[j]);
          check("vec_seg_len", log_len[j], vecs[i].slen[j]);
        end
      end
    end

    stall = 1;
    run_burst('h0, 31, 2'b01, 3'd1);
    check("long_seg_count", log_n, 8);
    check_model_segs('h0, 31);
    for (int k = 0; k < 12; k++) begin
      logic [AW-1:0] a;
      int l;
      a = AW'($urandom_range(0, 1023) * 2);
      l = int'($urandom_range(0, 40));
      stall = ($urandom_range(0, 3) != 0);
      run_burst(a, l, 2'b01, 3'd1);
      check_model_segs(a, l);
    end

    stall = 0;
    start_ar('h0, 7, 2'b01, 3'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_arready", s_axi_arready, 1'b0);
    check("midrst_rvalid", s_axi_rvalid, 1'b0);
    check("midrst_m_arvalid", m_axi_arvalid, 2'b00);
    check("midrst_m_rready", m_axi_rready, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_arready_release", s_axi_arready, 1'b1);
    run_burst(vecs[0].addr, vecs[0].len, vecs[0].burst, vecs[0].size);
    check("post_rst_seg_count", log_n, 2);
    check_model_segs(vecs[0].addr, vecs[0].len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
